// File: rtl/label_font_rom_sched_if.sv
// Config, text-write, pixel stream and font pROM signals of the label overlay.
interface label_font_rom_sched_if #(
  parameter int NUM_LABELS = 2,
  parameter int MAX_CHARS  = 16,
  parameter int XW         = 11
);
  localparam int LW = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1;
  localparam int IW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  logic                     frame_start;
  logic [NUM_LABELS-1:0]    cfg_en;
  logic [NUM_LABELS*XW-1:0] cfg_x0;
  logic [NUM_LABELS*XW-1:0] cfg_y0;
  logic [NUM_LABELS*5-1:0]  cfg_len;
  logic [NUM_LABELS*24-1:0] cfg_color;
  logic                     wr_en;
  logic [LW-1:0]            wr_label;
  logic [IW-1:0]            wr_idx;
  logic [7:0]               wr_char;
  logic                     in_de;
  logic [XW-1:0]            in_x;
  logic [XW-1:0]            in_y;
  logic [23:0]              in_rgb;
  logic                     rom_ce;
  logic                     rom_oce;
  logic [13:0]              rom_ad;
  logic                     rom_dout;
  logic                     out_de;
  logic [23:0]              out_rgb;

  modport master (
    output frame_start, cfg_en, cfg_x0, cfg_y0, cfg_len, cfg_color,
    output wr_en, wr_label, wr_idx, wr_char,
    output in_de, in_x, in_y, in_rgb, rom_dout,
    input  rom_ce, rom_oce, rom_ad, out_de, out_rgb
  );

  modport slave (
    input  frame_start, cfg_en, cfg_x0, cfg_y0, cfg_len, cfg_color,
    input  wr_en, wr_label, wr_idx, wr_char,
    input  in_de, in_x, in_y, in_rgb, rom_dout,
    output rom_ce, rom_oce, rom_ad, out_de, out_rgb
  );
endinterface

// File: rtl/label_font_rom_sched.sv
// Text-label overlay sharing one font pROM: priority box hit per pixel, glyph address, colour key.
// Fixed 3-cycle latency, one pixel per clock, no backpressure.
module label_font_rom_sched #(
  parameter int NUM_LABELS = 2,
  parameter int MAX_CHARS  = 16,
  parameter int XW         = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  label_font_rom_sched_if.slave bus
);
  localparam int IW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  logic [NUM_LABELS-1:0] en_q, en_d;
  logic [XW-1:0]         x0_q    [NUM_LABELS];
  logic [XW-1:0]         x0_d    [NUM_LABELS];
  logic [XW-1:0]         y0_q    [NUM_LABELS];
  logic [XW-1:0]         y0_d    [NUM_LABELS];
  logic [4:0]            len_q   [NUM_LABELS];
  logic [4:0]            len_d   [NUM_LABELS];
  logic [23:0]           color_q [NUM_LABELS];
  logic [23:0]           color_d [NUM_LABELS];
  logic [6:0]            txt_q   [NUM_LABELS][MAX_CHARS];
  logic [6:0]            txt_d   [NUM_LABELS][MAX_CHARS];

  logic wr_char_unused;
  assign wr_char_unused = bus.wr_char[7];

  // Shadows only move on frame_start so a frame never sees a half-updated label.
  always_comb begin
    en_d    = en_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    len_d   = len_q;
    color_d = color_q;
    if (bus.frame_start) begin
      en_d = bus.cfg_en;
      for (int i = 0; i < NUM_LABELS; i++) begin
        x0_d[i]    = bus.cfg_x0[i*XW +: XW];
        y0_d[i]    = bus.cfg_y0[i*XW +: XW];
        len_d[i]   = (bus.cfg_len[i*5 +: 5] > 5'(MAX_CHARS)) ? 5'(MAX_CHARS) : bus.cfg_len[i*5 +: 5];
        color_d[i] = bus.cfg_color[i*24 +: 24];
      end
    end
  end

  always_comb begin
    txt_d = txt_q;
    if (bus.wr_en && (int'(bus.wr_label) < NUM_LABELS))
      txt_d[bus.wr_label][bus.wr_idx] = bus.wr_char[6:0];
  end

  logic [XW:0]  dx, dy, lim;
  logic         hit0;
  logic [23:0]  col0;
  logic [13:0]  ad0;

  // Scan from the highest index down so the lowest-index hit is the one left standing.
  always_comb begin
    hit0 = 1'b0;
    col0 = '0;
    ad0  = '0;
    dx   = '0;
    dy   = '0;
    lim  = '0;
    for (int i = NUM_LABELS - 1; i >= 0; i--) begin
      dx  = {1'b0, bus.in_x} - {1'b0, x0_q[i]};
      dy  = {1'b0, bus.in_y} - {1'b0, y0_q[i]};
      lim = (XW+1)'({len_q[i], 3'b000});
      if (en_q[i] && (len_q[i] != '0) && !dx[XW] && (dx < lim) && (dy[XW:4] == '0)) begin
        hit0 = 1'b1;
        col0 = color_q[i];
        ad0  = {txt_q[i][dx[3 +: IW]], dx[2:0], dy[3:0]};
      end
    end
  end

  logic        de1_q, de1_d, ce1_q, ce1_d;
  logic [23:0] rgb1_q, rgb1_d, col1_q, col1_d;
  logic [13:0] ad1_q, ad1_d;
  logic        de2_q, de2_d, hit2_q, hit2_d;
  logic [23:0] rgb2_q, rgb2_d, col2_q, col2_d;
  logic        de3_q, de3_d;
  logic [23:0] rgb3_q, rgb3_d;

  always_comb begin
    de1_d  = bus.in_de;
    ce1_d  = bus.in_de & hit0;
    rgb1_d = bus.in_rgb;
    col1_d = col0;
    ad1_d  = ce1_d ? ad0 : ad1_q;
    de2_d  = de1_q;
    hit2_d = ce1_q;
    rgb2_d = rgb1_q;
    col2_d = col1_q;
    de3_d  = de2_q;
    rgb3_d = (hit2_q && bus.rom_dout) ? col2_q : rgb2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q <= '0;
      for (int i = 0; i < NUM_LABELS; i++) begin
        x0_q[i]    <= '0;
        y0_q[i]    <= '0;
        len_q[i]   <= '0;
        color_q[i] <= '0;
        for (int j = 0; j < MAX_CHARS; j++) txt_q[i][j] <= 7'h20;
      end
      de1_q  <= 1'b0;
      ce1_q  <= 1'b0;
      rgb1_q <= '0;
      col1_q <= '0;
      ad1_q  <= '0;
      de2_q  <= 1'b0;
      hit2_q <= 1'b0;
      rgb2_q <= '0;
      col2_q <= '0;
      de3_q  <= 1'b0;
      rgb3_q <= '0;
    end else begin
      en_q    <= en_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      len_q   <= len_d;
      color_q <= color_d;
      txt_q   <= txt_d;
      de1_q   <= de1_d;
      ce1_q   <= ce1_d;
      rgb1_q  <= rgb1_d;
      col1_q  <= col1_d;
      ad1_q   <= ad1_d;
      de2_q   <= de2_d;
      hit2_q  <= hit2_d;
      rgb2_q  <= rgb2_d;
      col2_q  <= col2_d;
      de3_q   <= de3_d;
      rgb3_q  <= rgb3_d;
    end
  end

  assign bus.rom_ce  = ce1_q;
  assign bus.rom_oce = 1'b1;
  assign bus.rom_ad  = ad1_q;
  assign bus.out_de  = de3_q;
  assign bus.out_rgb = rgb3_q;
endmodule

// File: tb/tb_label_font_rom_sched.sv
// Bench for label_font_rom_sched: directed scenarios then random pixels, checked against a
// box/priority reference model and a synchronous font pROM model.
module tb_label_font_rom_sched;
  localparam int NL    = 2;
  localparam int MC    = 16;
  localparam int XW    = 11;
  localparam int LW    = 1;
  localparam int IW    = 4;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  label_font_rom_sched_if #(.NUM_LABELS(NL), .MAX_CHARS(MC), .XW(XW)) bus();

  label_font_rom_sched #(.NUM_LABELS(NL), .MAX_CHARS(MC), .XW(XW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Glyph content: codes up to 0x20 blank, column 0 and row 0 blank, else a parity pattern.
  function automatic bit font_bit(input logic [13:0] ad);
    int code, col, row;
    code = int'(ad[13:7]);
    col  = int'(ad[6:4]);
    row  = int'(ad[3:0]);
    if (code <= 32 || col == 0 || row == 0) return 1'b0;
    return ((code ^ col ^ row) & 1) == 1;
  endfunction

  always @(posedge clk or posedge reset)
    if (reset) bus.rom_dout <= 1'b0;
    else if (bus.rom_ce) bus.rom_dout <= font_bit(bus.rom_ad);

  bit          m_en  [NL];
  int          m_x0  [NL];
  int          m_y0  [NL];
  int          m_len [NL];
  logic [23:0] m_col [NL];
  logic [6:0]  m_txt [NL][MC];
  logic [13:0] m_last_ad;

  bit          c_en  [NL];
  int          c_x0  [NL];
  int          c_y0  [NL];
  int          c_len [NL];
  logic [23:0] c_col [NL];

  bit          e_ce  [DEPTH];
  bit          e_de  [DEPTH];
  logic [13:0] e_ad  [DEPTH];
  logic [23:0] e_rgb [DEPTH];
  int stp;
  int n_assert;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_en[i] = 1'b0; m_x0[i] = 0; m_y0[i] = 0; m_len[i] = 0; m_col[i] = '0;
      for (int j = 0; j < MC; j++) m_txt[i][j] = 7'h20;
    end
    m_last_ad = '0;
  endtask

  task automatic step(input bit de, input int x, input int y, input logic [23:0] rgb,
                      input bit fs = 1'b0, input bit we = 1'b0, input int wl = 0,
                      input int wi = 0, input logic [7:0] wc = 8'h00);
    bit hit;
    int w, dx, dy;
    logic [13:0] ad;
    @(negedge clk);
    if (stp >= 1) begin
      chk($sformatf("rom_ce[%0d]", stp-1), 32'(bus.rom_ce), 32'(e_ce[stp-1]));
      chk($sformatf("rom_ad[%0d]", stp-1), 32'(bus.rom_ad), 32'(e_ad[stp-1]));
    end
    if (stp >= 3) begin
      chk($sformatf("out_de[%0d]", stp-3), 32'(bus.out_de), 32'(e_de[stp-3]));
      chk($sformatf("out_rgb[%0d]", stp-3), 32'(bus.out_rgb), 32'(e_rgb[stp-3]));
    end
    bus.in_de = de;
    bus.in_x = XW'(x);
    bus.in_y = XW'(y);
    bus.in_rgb = rgb;
    bus.frame_start = fs;
    bus.wr_en = we;
    bus.wr_label = LW'(wl);
    bus.wr_idx = IW'(wi);
    bus.wr_char = wc;
    for (int i = 0; i < NL; i++) begin
      bus.cfg_en[i] = c_en[i];
      bus.cfg_x0[i*XW +: XW] = XW'(c_x0[i]);
      bus.cfg_y0[i*XW +: XW] = XW'(c_y0[i]);
      bus.cfg_len[i*5 +: 5] = 5'(c_len[i]);
      bus.cfg_color[i*24 +: 24] = c_col[i];
    end
    hit = 1'b0; w = 0; ad = '0;
    for (int i = 0; i < NL; i++) begin
      if (!hit && m_en[i] && m_len[i] > 0) begin
        dx = x - m_x0[i];
        dy = y - m_y0[i];
        if (dx >= 0 && dx < 8 * m_len[i] && dy >= 0 && dy < 16) begin
          hit = 1'b1;
          w = i;
        end
      end
    end
    if (hit) begin
      dx = x - m_x0[w];
      dy = y - m_y0[w];
      ad = {m_txt[w][dx / 8], 3'(dx % 8), 4'(dy)};
    end
    e_ce[stp] = de && hit;
    if (de && hit) m_last_ad = ad;
    e_ad[stp] = m_last_ad;
    e_de[stp] = de;
    e_rgb[stp] = (de && hit && font_bit(ad)) ? m_col[w] : rgb;
    if (we && wl < NL) m_txt[wl][wi] = wc[6:0];
    if (fs) begin
      for (int i = 0; i < NL; i++) begin
        m_en[i] = c_en[i]; m_x0[i] = c_x0[i]; m_y0[i] = c_y0[i];
        m_len[i] = (c_len[i] > MC) ? MC : c_len[i];
        m_col[i] = c_col[i];
      end
    end
    stp++;
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 24'h0);
  endtask

  // Reset lands mid-cycle, right after a pixel was driven and before it is sampled.
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_out_de", 32'(bus.out_de), 32'd0);
    chk("rst_out_rgb", 32'(bus.out_rgb), 32'd0);
    chk("rst_rom_ce", 32'(bus.rom_ce), 32'd0);
    bus.in_de = 1'b0; bus.in_rgb = '0; bus.frame_start = 1'b0; bus.wr_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    for (int k = stp - 3; k < stp; k++) begin
      if (k >= 0) begin
        e_ce[k] = 1'b0; e_ad[k] = '0; e_de[k] = 1'b0; e_rgb[k] = '0;
      end
    end
    model_reset();
  endtask

  initial begin
    #1000000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_assert = 0; n_fail = 0; stp = 0;
    reset = 1'b1;
    bus.frame_start = 1'b0; bus.cfg_en = '0; bus.cfg_x0 = '0; bus.cfg_y0 = '0;
    bus.cfg_len = '0; bus.cfg_color = '0; bus.wr_en = 1'b0; bus.wr_label = '0;
    bus.wr_idx = '0; bus.wr_char = '0; bus.in_de = 1'b0; bus.in_x = '0; bus.in_y = '0;
    bus.in_rgb = '0;
    for (int i = 0; i < NL; i++) begin
      c_en[i] = 1'b0; c_x0[i] = 0; c_y0[i] = 0; c_len[i] = 0; c_col[i] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_out_de", 32'(bus.out_de), 32'd0);
    chk("reset_out_rgb", 32'(bus.out_rgb), 32'd0);
    chk("reset_rom_ce", 32'(bus.rom_ce), 32'd0);
    chk("reset_rom_oce", 32'(bus.rom_oce), 32'd1);
    chk("reset_rom_ad", 32'(bus.rom_ad), 32'd0);

    // 1: labels start disabled, everything passes through
    for (int n = 0; n < 20; n++)
      step(1'b1, 90 + int'($urandom_range(0, 40)), 45 + int'($urandom_range(0, 25)), 24'($urandom));

    // 2: label0 "AB" at (100,50)
    step(1'b0, 0, 0, 24'h0, 1'b0, 1'b1, 0, 0, 8'h41);
    step(1'b0, 0, 0, 24'h0, 1'b0, 1'b1, 0, 1, 8'h42);
    c_en[0] = 1'b1; c_x0[0] = 100; c_y0[0] = 50; c_len[0] = 2; c_col[0] = 24'hFF0000;
    step(1'b0, 0, 0, 24'h0, 1'b1);
    step(1'b1, 103, 53, 24'h123456);
    @(posedge clk); #1 chk("t2_rom_ad", 32'(bus.rom_ad), 32'h20B3);
    step(1'b1, 100, 50, 24'h0A0B0C);
    idle();
    @(posedge clk); #1 chk("t2_out_rgb", 32'(bus.out_rgb), 32'hFF0000);

    // 3: just outside the box, then the far corner of the second character
    step(1'b1, 99, 53, 24'h010203);
    step(1'b1, 116, 53, 24'h040506);
    step(1'b1, 103, 66, 24'h070809);
    step(1'b1, 115, 65, 24'h0A0B0C);
    @(posedge clk); #1 chk("t3_code", 32'(bus.rom_ad[13:7]), 32'h42);
    idle(); idle(); idle();

    // 4: overlapping labels, label0 wins on box even with a blank glyph
    step(1'b0, 0, 0, 24'h0, 1'b0, 1'b1, 1, 0, 8'h41);
    step(1'b0, 0, 0, 24'h0, 1'b0, 1'b1, 0, 0, 8'h20);
    c_en[1] = 1'b1; c_x0[1] = 100; c_y0[1] = 50; c_len[1] = 1; c_col[1] = 24'h00FF00;
    step(1'b0, 0, 0, 24'h0, 1'b1);
    step(1'b1, 103, 53, 24'h222222);
    @(posedge clk); #1 chk("t4_code_l0", 32'(bus.rom_ad[13:7]), 32'h20);
    c_en[0] = 1'b0;
    step(1'b0, 0, 0, 24'h0, 1'b1);
    step(1'b1, 103, 53, 24'h111111);
    idle(); idle();
    @(posedge clk); #1 chk("t4_out_l1", 32'(bus.out_rgb), 32'h00FF00);

    // 5: mid-frame cfg is ignored; length clamp; zero length
    c_en[0] = 1'b1;
    step(1'b0, 0, 0, 24'h0, 1'b1, 1'b1, 0, 0, 8'hC1);
    c_x0[0] = 300;
    step(1'b1, 103, 53, 24'h333333);
    @(posedge clk); #1 chk("t5_old_pos", 32'(bus.rom_ad[13:7]), 32'h41);
    c_len[0] = 20;
    step(1'b0, 0, 0, 24'h0, 1'b1, 1'b1, 0, 15, 8'h5A);
    step(1'b1, 427, 55, 24'h444444);
    @(posedge clk); #1 chk("t5_clamp_code", 32'(bus.rom_ad[13:7]), 32'h5A);
    step(1'b1, 428, 55, 24'h555555);
    @(posedge clk); #1 chk("t5_clamp_edge_ce", 32'(bus.rom_ce), 32'd0);
    c_len[0] = 0;
    step(1'b0, 0, 0, 24'h0, 1'b1);
    step(1'b1, 303, 53, 24'h666666);
    @(posedge clk); #1 chk("t5_len0_ce", 32'(bus.rom_ce), 32'd0);

    // 6: reset during an active line
    step(1'b1, 103, 53, 24'h777777);
    step(1'b1, 104, 54, 24'h888888);
    step(1'b1, 105, 55, 24'h999999);
    step(1'b1, 106, 56, 24'hAAAAAA);
    mid_reset();
    step(1'b1, 103, 53, 24'hBBBBBB);
    @(posedge clk); #1 chk("t6_labels_off", 32'(bus.rom_ce), 32'd0);
    for (int n = 0; n < 6; n++) step(1'b1, 100 + n, 53, 24'($urandom));

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      bit fs, we, de;
      int x, y;
      fs = ($urandom_range(0, 99) == 0);
      if (fs) begin
        for (int i = 0; i < NL; i++) begin
          c_en[i]  = ($urandom_range(0, 3) != 0);
          c_x0[i]  = ($urandom_range(0, 3) == 0) ? 2035 + int'($urandom_range(0, 9))
                                                  : 95 + int'($urandom_range(0, 19));
          c_y0[i]  = 48 + int'($urandom_range(0, 5));
          c_len[i] = int'($urandom_range(0, 20));
          c_col[i] = 24'($urandom);
        end
      end
      we = ($urandom_range(0, 9) == 0);
      de = ($urandom_range(0, 9) != 0);
      x  = ($urandom_range(0, 7) == 0) ? 2030 + int'($urandom_range(0, 17))
                                        : 90 + int'($urandom_range(0, 159));
      y  = 45 + int'($urandom_range(0, 29));
      step(de, x, y, 24'($urandom), fs, we, int'($urandom_range(0, NL-1)),
           int'($urandom_range(0, MC-1)), 8'($urandom));
    end
    idle(); idle(); idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
